// File: rtl/gnr_ctrl_pkg.sv
// gnr_ctrl_pkg
//   Shared definitions for the gene-regulatory-network attractor controller:
//   controller state encoding, default network/counter widths and the
//   saturating-increment helper used by gnr_sat_counter.
package gnr_ctrl_pkg;

  localparam int N_DEF  = 16;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEARCH = 3'd2,
    PERIOD = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Increment value, holding at the all-ones pattern of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] limit;
    limit = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value >= limit) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/gnr_sat_counter.sv
// gnr_sat_counter
//   W-bit up counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in  clock
//     rst   in  synchronous active-high reset (count -> 0)
//     en    in  increment by one (saturating)
//     clr   in  force count to 0; has priority over en
//     count out current count
module gnr_sat_counter
  import gnr_ctrl_pkg::*;
#(
  parameter int W = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = W'(sat_inc(64'(count), W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl
//   Run controller for the Boolean GRN node array. Loads an initial state into
//   both node copies, runs Floyd cycle detection (tortoise s0 at half rate via
//   the node pass bit, hare s1 at full rate), then freezes the tortoise and
//   steps the hare once around the attractor to measure its period.
//   Optional build macro: GNR_TIMEOUT_EN -- aborts a run once h + p reaches
//   MAX_STEPS and reports it on out_timeout; undefined, out_timeout stays 0.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid/in_ready/in_state  initial-state handshake (ready only in IDLE)
//     reset_nos, init_state     load strobe and value for both node copies
//     start_s0, start_s1        tortoise / hare enables
//     s0_vec, s1_vec            registered node state copies
//     out_valid/out_ready       result handshake
//     out_steps, out_period     hare steps at meeting, attractor period
//     out_attr, out_timeout     state on the attractor, step-limit abort flag
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int          N         = N_DEF,
  parameter int          CW        = CW_DEF,
  parameter int unsigned MAX_STEPS = 32'hFFF0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_state,
  output logic          reset_nos,
  output logic [N-1:0]  init_state,
  output logic          start_s0,
  output logic          start_s1,
  input  logic [N-1:0]  s0_vec,
  input  logic [N-1:0]  s1_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_steps,
  output logic [CW-1:0] out_period,
  output logic [N-1:0]  out_attr,
  output logic          out_timeout
);

  state_t        state_reg, state_next;
  logic [CW-1:0] h_cnt, p_cnt;
  logic [N-1:0]  attr_reg;
  logic          accept, states_eq, meet, per_match, limit_hit, enter_done;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign states_eq = (s0_vec == s1_vec);
  // Tortoise and hare can only coincide meaningfully after an even, non-zero
  // number of hare steps (tortoise has then taken exactly h/2).
  assign meet      = (state_reg == SEARCH) && (h_cnt != '0) && !h_cnt[0] && states_eq;
  assign per_match = (state_reg == PERIOD) && (p_cnt != '0) && states_eq;

`ifdef GNR_TIMEOUT_EN
  assign limit_hit = ((state_reg == SEARCH) || (state_reg == PERIOD)) &&
                     ((33'(h_cnt) + 33'(p_cnt)) >= 33'(MAX_STEPS));
`else
  assign limit_hit = 1'b0;
  logic unused_max_steps;
  assign unused_max_steps = (MAX_STEPS == 0);
`endif

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    reset_nos  = 1'b0;
    start_s0   = 1'b0;
    start_s1   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        reset_nos  = 1'b1;
        state_next = SEARCH;
      end
      SEARCH: begin
        if (limit_hit) begin
          state_next = DONE;
        end else if (meet) begin
          state_next = PERIOD;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
        end
      end
      PERIOD: begin
        if (limit_hit || per_match) begin
          state_next = DONE;
        end else begin
          start_s1 = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  gnr_sat_counter #(.W(CW)) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    ((state_reg == SEARCH) && start_s1),
    .clr   (accept),
    .count (h_cnt)
  );

  gnr_sat_counter #(.W(CW)) u_p_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    ((state_reg == PERIOD) && start_s1),
    .clr   (accept || meet),
    .count (p_cnt)
  );

  // Results are published only when DONE is entered so the outputs stay
  // stable for the whole run; h and p are frozen by then anyway.
  assign enter_done = (state_reg != DONE) && (state_next == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      init_state  <= '0;
      attr_reg    <= '0;
      out_steps   <= '0;
      out_period  <= '0;
      out_attr    <= '0;
      out_timeout <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        init_state <= in_state;
        attr_reg   <= '0;
      end
      if (meet) attr_reg <= s1_vec;
      if (enter_done) begin
        out_steps   <= h_cnt;
        out_period  <= p_cnt;
        out_attr    <= meet ? s1_vec : attr_reg;
        out_timeout <= limit_hit;
      end
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb_gnr_attractor_ctrl
//   Directed bench for gnr_attractor_ctrl with a small behavioural node array
//   (selectable next-state function, tortoise pass bit) attached to it.
//   With GNR_TIMEOUT_EN defined the step limit is set above the h+p of the
//   short scenarios so only the 16-state cycle run is cut short.
module tb_gnr_attractor_ctrl;

  localparam int N  = 4;
  localparam int CW = 16;
`ifdef GNR_TIMEOUT_EN
  localparam int unsigned MAX_STEPS = 40;
`else
  localparam int unsigned MAX_STEPS = 32'hFFF0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_state;
  logic          reset_nos;
  logic [N-1:0]  init_state;
  logic          start_s0;
  logic          start_s1;
  logic [N-1:0]  s0_vec;
  logic [N-1:0]  s1_vec;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_steps;
  logic [CW-1:0] out_period;
  logic [N-1:0]  out_attr;
  logic          out_timeout;

  int checks   = 0;
  int failures = 0;
  int net_sel  = 0;

  gnr_attractor_ctrl #(.N(N), .CW(CW), .MAX_STEPS(MAX_STEPS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .reset_nos   (reset_nos),
    .init_state  (init_state),
    .start_s0    (start_s0),
    .start_s1    (start_s1),
    .s0_vec      (s0_vec),
    .s1_vec      (s1_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_steps   (out_steps),
    .out_period  (out_period),
    .out_attr    (out_attr),
    .out_timeout (out_timeout)
  );

  always #5 clk = ~clk;

  // 0: fixed point, 1: 3-bit rotate, 2: counter 0..7 wrapping 7->4,
  // 3: 4-bit free-running counter (16-state cycle).
  function automatic logic [N-1:0] net_next(input int sel, input logic [N-1:0] s);
    case (sel)
      0:       return s;
      1:       return {1'b0, s[1:0], s[2]};
      2:       return (s == 4'd7) ? 4'd4 : s + 4'd1;
      default: return s + 4'd1;
    endcase
  endfunction

  // Node array: s1 steps on every start_s1, s0 steps on every other start_s0.
  logic pass_q;
  always @(posedge clk) begin
    if (rst) begin
      s0_vec <= '0;
      s1_vec <= '0;
      pass_q <= 1'b0;
    end else if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      pass_q <= 1'b0;
    end else begin
      if (start_s1) s1_vec <= net_next(net_sel, s1_vec);
      if (start_s0) begin
        pass_q <= ~pass_q;
        if (!pass_q) s0_vec <= net_next(net_sel, s0_vec);
      end
    end
  end

  // Offers one initial state, waits (bounded) for the result, consumes it.
  // cyc counts negedges from the LOAD cycle to the first DONE cycle.
  task automatic run_once(input int sel, input logic [N-1:0] init,
                          output logic [CW-1:0] st, output logic [CW-1:0] pe,
                          output logic [N-1:0] at, output logic to,
                          output int cyc, output bit seen);
    net_sel = sel;
    @(negedge clk);
    in_state = init;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_state = ~init;
    cyc = 0;
    while (!out_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    seen = out_valid;
    st   = out_steps;
    pe   = out_period;
    at   = out_attr;
    to   = out_timeout;
    $display("run net=%0d init=%h steps=%0d period=%0d attr=%h timeout=%0b cycles=%0d done=%0b",
             sel, init, st, pe, at, to, cyc, seen);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({reset_nos, start_s0, start_s1, out_valid, out_timeout} !== 5'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b expected=00000",
        {reset_nos, start_s0, start_s1, out_valid, out_timeout}); end
    checks++;
    if (init_state !== 4'h0 || out_steps !== 16'd0 || out_period !== 16'd0 || out_attr !== 4'h0)
      begin failures++; $display("FAIL reset_data got init=%h steps=%0d period=%0d attr=%h expected all 0",
        init_state, out_steps, out_period, out_attr); end
    checks++;
    if (in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_in_ready got=%b expected=1", in_ready); end
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_fixed_point();
    logic [CW-1:0] st, pe; logic [N-1:0] at; logic to; int cyc; bit seen;
    run_once(0, 4'b0101, st, pe, at, to, cyc, seen);
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL fixed_done got=%0b expected=1", seen); end
    checks++; if (st !== 16'd2) begin failures++; $display("FAIL fixed_steps got=%0d expected=2", st); end
    checks++; if (pe !== 16'd1) begin failures++; $display("FAIL fixed_period got=%0d expected=1", pe); end
    checks++; if (at !== 4'b0101) begin failures++; $display("FAIL fixed_attr got=%h expected=5", at); end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL fixed_timeout got=%0b expected=0", to); end
    checks++; if (cyc != 6) begin failures++; $display("FAIL fixed_latency got=%0d expected=6", cyc); end
    checks++; if (init_state !== 4'b0101) begin failures++; $display("FAIL fixed_init_state got=%h expected=5", init_state); end
  endtask

  task automatic test_ring_rotate();
    logic [CW-1:0] st, pe; logic [N-1:0] at; logic to; int cyc; bit seen;
    run_once(1, 4'b0001, st, pe, at, to, cyc, seen);
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL ring_done got=%0b expected=1", seen); end
    checks++; if (st !== 16'd6) begin failures++; $display("FAIL ring_steps got=%0d expected=6", st); end
    checks++; if (pe !== 16'd3) begin failures++; $display("FAIL ring_period got=%0d expected=3", pe); end
    checks++; if (at !== 4'b0001) begin failures++; $display("FAIL ring_attr got=%h expected=1", at); end
  endtask

  // Transient 0,1,2,3 then cycle 4..7: hare meets tortoise at h=8 on state 4.
  task automatic test_transient();
    logic [CW-1:0] st, pe; logic [N-1:0] at; logic to; int cyc; bit seen;
    run_once(2, 4'b0000, st, pe, at, to, cyc, seen);
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL trans_done got=%0b expected=1", seen); end
    checks++; if (st !== 16'd8) begin failures++; $display("FAIL trans_steps got=%0d expected=8", st); end
    checks++; if (pe !== 16'd4) begin failures++; $display("FAIL trans_period got=%0d expected=4", pe); end
    checks++; if (at !== 4'h4) begin failures++; $display("FAIL trans_attr got=%h expected=4", at); end
    checks++; if (cyc != 15) begin failures++; $display("FAIL trans_latency got=%0d expected=15", cyc); end
  endtask

  // 16-state cycle from 0: meet at h=32. With the step limit at 40 the run
  // stops in PERIOD at p=8.
  task automatic test_long_cycle();
    logic [CW-1:0] st, pe; logic [N-1:0] at; logic to; int cyc; bit seen;
    logic [CW-1:0] exp_pe; logic exp_to;
`ifdef GNR_TIMEOUT_EN
    exp_pe = 16'd8;  exp_to = 1'b1;
`else
    exp_pe = 16'd16; exp_to = 1'b0;
`endif
    run_once(3, 4'b0000, st, pe, at, to, cyc, seen);
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL long_done got=%0b expected=1", seen); end
    checks++; if (st !== 16'd32) begin failures++; $display("FAIL long_steps got=%0d expected=32", st); end
    checks++; if (pe !== exp_pe) begin failures++; $display("FAIL long_period got=%0d expected=%0d", pe, exp_pe); end
    checks++; if (to !== exp_to) begin failures++; $display("FAIL long_timeout got=%0b expected=%0b", to, exp_to); end
    checks++; if (at !== 4'h0) begin failures++; $display("FAIL long_attr got=%h expected=0", at); end
  endtask

  task automatic test_backpressure();
    int cyc;
    net_sel = 0;
    @(negedge clk);
    in_state = 4'b0110;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 400) begin @(negedge clk); cyc++; end
    // Offer the next state while DONE is held: it must be ignored for now.
    in_valid = 1'b1;
    in_state = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_steps !== 16'd2 ||
          out_period !== 16'd1 || out_attr !== 4'b0110) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b steps=%0d period=%0d attr=%h expected 1 0 2 1 6",
                 i, out_valid, in_ready, out_steps, out_period, out_attr);
      end
      @(negedge clk);
    end
    $display("backpressure hold 10 cycles");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL bp_idle got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (reset_nos !== 1'b1 || init_state !== 4'b0011 || in_ready !== 1'b0)
      begin failures++; $display("FAIL bp_accept got reset_nos=%b init=%h ready=%b expected 1 3 0",
        reset_nos, init_state, in_ready); end
    cyc = 0;
    while (!out_valid && cyc < 400) begin @(negedge clk); cyc++; end
    checks++;
    if (out_valid !== 1'b1 || out_steps !== 16'd2 || out_period !== 16'd1 || out_attr !== 4'b0011)
      begin failures++; $display("FAIL bp_second got valid=%b steps=%0d period=%0d attr=%h expected 1 2 1 3",
        out_valid, out_steps, out_period, out_attr); end
    $display("backpressure second run steps=%0d period=%0d attr=%h", out_steps, out_period, out_attr);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] st, pe; logic [N-1:0] at; logic to; int cyc; bit seen;
    net_sel = 1;
    @(negedge clk);
    in_state = 4'b0001;
    in_valid = 1'b1;
    @(negedge clk);           // LOAD
    in_valid = 1'b0;
    repeat (4) @(negedge clk); // SEARCH with h=3
    checks++;
    if (start_s0 !== 1'b1 || start_s1 !== 1'b1)
      begin failures++; $display("FAIL mid_search got s0=%b s1=%b expected 1 1", start_s0, start_s1); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, reset_nos, start_s0, start_s1, out_valid, out_timeout} !== 6'b100000)
      begin failures++; $display("FAIL mid_reset_ctrl got=%b expected=100000",
        {in_ready, reset_nos, start_s0, start_s1, out_valid, out_timeout}); end
    checks++;
    if (init_state !== 4'h0 || out_steps !== 16'd0 || out_period !== 16'd0 || out_attr !== 4'h0)
      begin failures++; $display("FAIL mid_reset_data got init=%h steps=%0d period=%0d attr=%h expected all 0",
        init_state, out_steps, out_period, out_attr); end
    rst = 1'b0;
    $display("reset mid-search applied");
    run_once(1, 4'b0001, st, pe, at, to, cyc, seen);
    checks++;
    if (seen !== 1'b1 || st !== 16'd6 || pe !== 16'd3 || at !== 4'b0001)
      begin failures++; $display("FAIL mid_rerun got done=%0b steps=%0d period=%0d attr=%h expected 1 6 3 1",
        seen, st, pe, at); end
  endtask

  initial begin
    test_reset();
    test_fixed_point();
    test_ring_rotate();
    test_transient();
    test_long_cycle();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
